// File: rtl/operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : operand_sequencer
// Purpose  : Collects five operands into a..e, issues the frame to an external
//            two-stage adder/subtract/AND pipeline when the result FIFO has
//            room for it, and buffers the returned results in a FIFO.
// Options  : OPERAND_SEQUENCER_FLUSH_EN adds a synchronous 'flush' input that
//            drops a partially collected or waiting frame.
// Revision : 1.0 - initial release
// ============================================================================
module operand_sequencer #(
  parameter int RES_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
`ifdef OPERAND_SEQUENCER_FLUSH_EN
  input  logic       flush,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_data,
  output logic [4:0] a,
  output logic [4:0] b,
  output logic [4:0] c,
  output logic [4:0] d,
  output logic [4:0] e,
  output logic       issue,
  input  logic [4:0] s_in,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [4:0] res_data
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW:0]   C_DEPTH   = RES_DEPTH[CW:0];
  localparam logic [CW-1:0] C_FULL    = RES_DEPTH[CW-1:0];
  localparam logic [CW-1:0] C_CNT_ONE = 1;
  localparam logic [AW-1:0] C_PTR_ONE = 1;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_FULL    = 1'b1
  } state_t;

  state_t        state_q;
  logic [2:0]    slot_q;
  logic [4:0]    a_q, b_q, c_q, d_q, e_q;
  logic          p0_q, p1_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    mem_q [RES_DEPTH];

  logic          w_accept;
  logic          w_credit;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic [1:0]    w_inflight;

  // Credit: buffered results plus frames still in the pipe must leave a slot.
  assign w_inflight = {1'b0, p0_q} + {1'b0, p1_q};
  assign w_credit   = ({1'b0, count_q} + {{(CW-1){1'b0}}, w_inflight}) < C_DEPTH;

`ifdef OPERAND_SEQUENCER_FLUSH_EN
  assign in_ready = (state_q == S_COLLECT) && !flush;
  assign issue    = (state_q == S_FULL) && w_credit && !flush;
`else
  assign in_ready = (state_q == S_COLLECT);
  assign issue    = (state_q == S_FULL) && w_credit;
`endif

  assign w_accept = in_valid && in_ready;

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign d = d_q;
  assign e = e_q;

  // Collect/issue FSM: steer accepted operands into their slot, wait for credit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_COLLECT;
      slot_q  <= 3'd0;
      a_q     <= 5'd0;
      b_q     <= 5'd0;
      c_q     <= 5'd0;
      d_q     <= 5'd0;
      e_q     <= 5'd0;
    end
`ifdef OPERAND_SEQUENCER_FLUSH_EN
    else if (flush) begin
      state_q <= S_COLLECT;
      slot_q  <= 3'd0;
    end
`endif
    else if (state_q == S_COLLECT) begin
      if (w_accept) begin
        case (slot_q)
          3'd0:    a_q <= in_data;
          3'd1:    b_q <= in_data;
          3'd2:    c_q <= in_data;
          3'd3:    d_q <= in_data;
          default: e_q <= in_data;
        endcase
        if (slot_q == 3'd4) begin
          slot_q  <= 3'd0;
          state_q <= S_FULL;
        end else begin
          slot_q <= slot_q + 3'd1;
        end
      end
    end else begin
      // Operands stay frozen until credit lets the frame go out.
      if (w_credit) begin
        state_q <= S_COLLECT;
      end
    end
  end

  // In-flight tracker mirroring the two-cycle latency of the downstream pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_q <= 1'b0;
      p1_q <= 1'b0;
    end else begin
      p0_q <= issue;
      p1_q <= p0_q;
    end
  end

  assign w_push    = p1_q;
  assign res_valid = (count_q != '0);
  assign w_pop     = res_valid && res_ready;
  assign w_full    = (count_q == C_FULL);

  // Occupancy next state; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  // Result storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= s_in;
    end
  end

  // Head is shown directly; forced to zero while empty so reset reads back 0.
  assign res_data = res_valid ? mem_q[rd_ptr_q] : 5'd0;

  // The credit rule must make a push into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset) !(w_push && w_full));

endmodule
`default_nettype wire

// File: tb/tb_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_sequencer
// Purpose  : Directed, table-driven bench for operand_sequencer with a model
//            of the downstream two-stage ((a+b)-(c+d)) & e pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_sequencer;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic [4:0] a, b, c, d, e;
  logic       issue;
  logic [4:0] s_in;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_data;

  int checks;
  int errors;

  typedef struct packed {
    logic [24:0] ops;
    logic [4:0]  res;
  } vec_t;

  vec_t vecs [7];

  operand_sequencer #(.RES_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef OPERAND_SEQUENCER_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .issue     (issue),
    .s_in      (s_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream pipeline model: two registered stages.
  logic [4:0] st1, st2;
  always @(posedge clk) begin
    st1 <= ((a + b) - (c + d)) & e;
    st2 <= st1;
  end
  assign s_in = st2;

  function automatic logic [4:0] op_at(input logic [24:0] ops, input int i);
    return ops[24 - 5*i -: 5];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next cycle; inputs are applied 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  // Five accepts; afterwards the bench sits in the FULL cycle.
  task automatic send_ops(input logic [24:0] ops);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = op_at(ops, i);
      #1;
      chk("collect_in_ready", {31'd0, in_ready}, 32'd1);
      chk("collect_no_issue", {31'd0, issue}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    in_data  = 5'd0;
    #1;
  endtask

  task automatic check_ops(input string name, input logic [24:0] ops);
    chk(name, {7'd0, a, b, c, d, e}, {7'd0, ops});
  endtask

  // Full frame with res_ready=1: issue once, result 3 cycles later.
  task automatic run_frame(input logic [24:0] ops, input logic [4:0] exp);
    int n;
    res_ready = 1'b1;
    send_ops(ops);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("issue", {31'd0, issue}, 32'd1);
    check_ops("operands", ops);
    step();
    #1;
    chk("issue_once", {31'd0, issue}, 32'd0);
    n = 1;
    while (!res_valid && n < 10) begin
      step();
      #1;
      n++;
    end
    chk("result_latency", n, 32'd3);
    chk("res_data", {27'd0, res_data}, {27'd0, exp});
    check_ops("operand_hold", ops);
    step();
  endtask

  initial begin
    int issues;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 5'd0;
    res_ready = 1'b0;

    vecs[0] = '{ops: {5'd3,  5'd4,  5'd1,  5'd2, 5'd7},  res: 5'd4};
    vecs[1] = '{ops: {5'd20, 5'd20, 5'd1,  5'd2, 5'd31}, res: 5'd5};
    vecs[2] = '{ops: {5'd1,  5'd0,  5'd2,  5'd0, 5'd21}, res: 5'd21};
    vecs[3] = '{ops: {5'd0,  5'd0,  5'd0,  5'd0, 5'd0},  res: 5'd0};
    vecs[4] = '{ops: {5'd31, 5'd31, 5'd0,  5'd0, 5'd31}, res: 5'd30};
    vecs[5] = '{ops: {5'd5,  5'd6,  5'd10, 5'd1, 5'd15}, res: 5'd0};
    vecs[6] = '{ops: {5'd10, 5'd3,  5'd4,  5'd2, 5'd12}, res: 5'd4};

    // Reset state while reset is held.
    #2;
    chk("rst_issue", {31'd0, issue}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {27'd0, res_data}, 32'd0);
    check_ops("rst_operands", 25'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Table of single frames.
    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].ops, vecs[v].res);
    end

    // Backpressure: four results fill the FIFO, fifth frame waits.
    res_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      send_ops(vecs[f].ops);
      chk("bp_issue", {31'd0, issue}, 32'd1);
      step();
    end
    send_ops(vecs[4].ops);
    for (int k = 0; k < 4; k++) begin
      chk("bp_stall_issue", {31'd0, issue}, 32'd0);
      chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      #1;
    end
    check_ops("bp_stall_operands", vecs[4].ops);
    chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
    chk("bp_head", {27'd0, res_data}, {27'd0, vecs[0].res});
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    #1;
    chk("bp_issue_after_pop", {31'd0, issue}, 32'd1);
    step();
    step();
    step();
    #1;
    res_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("bp_drain_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_drain_data", {27'd0, res_data}, {27'd0, vecs[k].res});
      step();
      #1;
    end
    chk("bp_drained", {31'd0, res_valid}, 32'd0);
    step();

    // Reset after three accepts discards the partial frame.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 5'd9 + 5'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_ops("async_rst_operands", 25'd0);
    chk("async_rst_res_valid", {31'd0, res_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    run_frame(vecs[0].ops, vecs[0].res);
    chk("rst_no_stale", {31'd0, res_valid}, 32'd0);

    // Throughput: in_valid held high gives one issue every six cycles.
    do_reset();
    step();
    res_ready = 1'b1;
    issues    = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_data  = 5'(i);
      #1;
      if (issue) issues++;
      if (i == 5) chk("tp_first_issue", {31'd0, issue}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    chk("tp_issue_count", issues, 32'd3);
    do_reset();
    step();

`ifdef OPERAND_SEQUENCER_FLUSH_EN
    // Flush after two accepts, then a clean frame.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 5'd17;
      step();
    end
    flush    = 1'b1;
    in_data  = 5'd5;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("flush_issue", {31'd0, issue}, 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    run_frame(vecs[0].ops, vecs[0].res);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
